// File: rtl/inst_cache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } cache_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Word-offset field width within a line.
  function automatic int offsetBits(input int words);
    return $clog2(words);
  endfunction

  // Line-index field width.
  function automatic int indexBits(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: everything above byte offset, word offset and index.
  function automatic int tagBits(input int lines, input int words);
    return 30 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// master = IF stage plus main memory, slave = the cache itself.
interface inst_cache_if;
  logic [31:0] InstMemAddr;
  logic [31:0] Inst;
  logic        Stall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        MemValid;

  modport master (
    output InstMemAddr, MemData, MemValid,
    input  Inst, Stall, MemReq, MemAddr
  );

  modport slave (
    input  InstMemAddr, MemData, MemValid,
    output Inst, Stall, MemReq, MemAddr
  );
endinterface

// File: rtl/icache_tag_store.sv
// Valid/tag/data arrays of the instruction cache: combinational read port,
// one full-line write port; only the valid bits are cleared by reset.
module icache_tag_store
  import inst_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int IDX_W = indexBits(LINES),
  parameter int TAG_W = tagBits(LINES, WORDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IDX_W-1:0]       rdIdx_i,
  output logic                   rdValid_o,
  output logic [TAG_W-1:0]       rdTag_o,
  output logic [WORDS-1:0][31:0] rdLine_o,
  input  logic                   wrEn_i,
  input  logic [IDX_W-1:0]       wrIdx_i,
  input  logic [TAG_W-1:0]       wrTag_i,
  input  logic [WORDS-1:0][31:0] wrLine_i
);

  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [WORDS-1:0][31:0] data_q [LINES];

  // Valid bits: cleared asynchronously so a half-filled line never becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wrEn_i) begin
      valid_q[wrIdx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: written only when a refill completes, never reset.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      tag_q[wrIdx_i]  <= wrTag_i;
      data_q[wrIdx_i] <= wrLine_i;
    end
  end

  assign rdValid_o = valid_q[rdIdx_i];
  assign rdTag_o   = tag_q[rdIdx_i];
  assign rdLine_o  = data_q[rdIdx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
// Optional hit/miss statistics counters are enabled by defining INST_CACHE_STATS_EN.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  inst_cache_if.slave bus
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int OFF_W   = offsetBits(WORDS);
  localparam int IDX_W   = indexBits(LINES);
  localparam int TAG_W   = tagBits(LINES, WORDS);
  localparam int IDX_LSB = OFF_W + 2;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  cache_state_e           state_q;
  logic [OFF_W-1:0]       beat_q;
  logic                   memReq_q;
  logic [31:0]            memAddr_q;
  logic [IDX_W-1:0]       fillIdx_q;
  logic [TAG_W-1:0]       fillTag_q;
  logic [WORDS-1:0][31:0] lineBuf_q;

  logic [OFF_W-1:0]       reqOff;
  logic [IDX_W-1:0]       reqIdx;
  logic [TAG_W-1:0]       reqTag;
  logic                   rdValid;
  logic [TAG_W-1:0]       rdTag;
  logic [WORDS-1:0][31:0] rdLine;
  logic                   hit;
  logic                   lastBeat;
  logic                   fillWr;
  logic [WORDS-1:0][31:0] fillLine;
  logic                   unusedByteBits;

  assign reqOff = bus.InstMemAddr[IDX_LSB-1:2];
  assign reqIdx = bus.InstMemAddr[TAG_LSB-1:IDX_LSB];
  assign reqTag = bus.InstMemAddr[31:TAG_LSB];

  // Byte-offset bits play no part in the lookup; misalignment is not checked.
  assign unusedByteBits = ^bus.InstMemAddr[1:0];

  assign hit      = rdValid && (rdTag == reqTag);
  assign lastBeat = (beat_q == OFF_W'(WORDS - 1));
  assign fillWr   = (state_q == REFILL) && bus.MemValid && lastBeat;

  assign bus.Stall   = (state_q != IDLE) || !hit;
  assign bus.Inst    = ((state_q == IDLE) && hit) ? rdLine[reqOff] : NOP_INST;
  assign bus.MemReq  = memReq_q;
  assign bus.MemAddr = memAddr_q;

  // Full line to commit: buffered beats plus the word arriving on the final beat.
  always_comb begin
    fillLine            = lineBuf_q;
    fillLine[WORDS-1]   = bus.MemData;
  end

  icache_tag_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst),
    .rdIdx_i   (reqIdx),
    .rdValid_o (rdValid),
    .rdTag_o   (rdTag),
    .rdLine_o  (rdLine),
    .wrEn_i    (fillWr),
    .wrIdx_i   (fillIdx_q),
    .wrTag_i   (fillTag_q),
    .wrLine_i  (fillLine)
  );

  // Miss/refill controller: latches the missing line, walks its beats, then pauses one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
      fillIdx_q <= '0;
      fillTag_q <= '0;
      lineBuf_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            state_q   <= REFILL;
            beat_q    <= '0;
            memReq_q  <= 1'b1;
            memAddr_q <= {bus.InstMemAddr[31:IDX_LSB], {IDX_LSB{1'b0}}};
            fillIdx_q <= reqIdx;
            fillTag_q <= reqTag;
          end
        end
        REFILL: begin
          if (bus.MemValid) begin
            lineBuf_q[beat_q] <= bus.MemData;
            beat_q            <= beat_q + OFF_W'(1);
            if (lastBeat) begin
              memReq_q <= 1'b0;
              state_q  <= DONE;
            end else begin
              memAddr_q <= memAddr_q + 32'd4;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef INST_CACHE_STATS_EN
  logic [31:0] hitCount_q;
  logic [31:0] missCount_q;

  // Saturating lookup statistics, sampled only while the cache is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else if (state_q == IDLE) begin
      if (hit && (hitCount_q != 32'hFFFF_FFFF)) begin
        hitCount_q <= hitCount_q + 32'd1;
      end
      if (!hit && (missCount_q != 32'hFFFF_FFFF)) begin
        missCount_q <= missCount_q + 32'd1;
      end
    end
  end

  assign HitCount  = hitCount_q;
  assign MissCount = missCount_q;
`endif

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's IF stage and a slow, word-serial main instruction memory.
- Serves InstMemAddr combinationally on a hit.
- On a miss it raises Stall, which the hazard path ORs into PCWrite/IFIDWrite deassertion, and refills one full line through a valid-handshake memory port.

Parameters:
- LINES, 8, number of cache lines (power of two, >=2).
- WORDS, 4, 32-bit words per line (power of two, >=2).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- InstMemAddr  input  32  fetch byte address from PC.
- Inst  output  32  instruction word to IF/ID.
- Stall  output  1  fetch not served this cycle; freeze PC and IF/ID.
- MemReq  output  1  refill beat request to main memory.
- MemAddr  output  32  word-aligned address of the requested beat.
- MemData  input  32  returned word.
- MemValid  input  1  MemData valid; completes the current beat.

Behaviour:
- Address split:
  - [1:0] ignored (misalignment not checked).
  - [log2(WORDS)+1:2] word offset.
  - Next log2(LINES) bits index.
  - Remaining upper bits tag.
- Storage per line: valid bit, tag, WORDS data words. Written only at refill end; never read-modify-written otherwise.
- States: IDLE, REFILL, DONE.
- IDLE:
  - hit = valid[idx] & tag match.
  - Hit: Inst = selected word, Stall = 0, zero-cycle latency.
  - Miss: Inst = 32'h0 (NOP), Stall = 1. Latch line base address (offset bits zeroed), clear beat counter, go to REFILL next edge.
- REFILL:
  - MemReq = 1; MemAddr = latched base + 4*beat, held stable until MemValid.
  - On MemValid: store MemData into line buffer slot [beat], beat++.
  - On the MemValid of beat WORDS-1: write buffer, tag and valid=1 into the indexed line; go to DONE.
  - Stall = 1, Inst = 0 throughout.
- DONE: MemReq = 0, Stall = 1, Inst = 0. One cycle, then IDLE. Re-lookup then hits.
- Miss penalty: 1 + (sum of memory beat latencies) + 1 cycles; minimum WORDS+2 with single-cycle memory.
- Conflict eviction: refill into an index holding another tag overwrites that line unconditionally.
- InstMemAddr changes during REFILL/DONE are ignored; the latched line completes. The new address is looked up in IDLE.
- MemValid while MemReq = 0 is ignored.
- Beat counter is log2(WORDS) bits; it wraps to 0 only via the REFILL->DONE transition and is cleared on every miss entry.
- Reset (async, any state, including mid-refill):
  - state IDLE, all valid bits 0, beat 0, MemReq 0, MemAddr 0.
  - A partially fetched line stays invalid.
  - Data array contents need not be reset.
- After reset every lookup misses: Stall = 1, Inst = 0.

Optional Feature:
- Macro INST_CACHE_STATS_EN.
- When defined, adds outputs HitCount[31:0] and MissCount[31:0].
  - HitCount increments each IDLE cycle with hit.
  - MissCount increments on each IDLE->REFILL transition.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package inst_cache_pkg: state enum typedef (IDLE, REFILL, DONE), NOP_INST = 32'h0, and functions computing index/offset/tag widths from LINES and WORDS.
- One sub-module, icache_tag_store: valid/tag/data arrays with async clear of valid, combinational read port, single full-line write port.
- FSM, beat counter and memory port stay in inst_cache.

Test Plan (LINES=8, WORDS=4, memory answers MemValid 2 cycles after each new MemAddr):
- Cold miss: release reset, InstMemAddr=0x40 -> Stall=1, Inst=0; MemAddr sequence 0x40,0x44,0x48,0x4C with MemReq high; DONE cycle; then Stall=0, Inst=word0.
- Spatial hits after refill: 0x44, 0x48, 0x4C on consecutive cycles -> Stall=0 each cycle, Inst = words 1..3, MemReq stays 0.
- Conflict eviction: 0xC0 (index 4, tag 1) -> full refill at 0xC0..0xCC; then 0x40 misses again and refills.
- Address change mid-refill: switch InstMemAddr from 0x80 to 0x100 during beat 1 -> MemAddr continues 0x88, 0x8C; line 0 filled; then 0x100 misses.
- Reset mid-refill: assert rst after beat 2 of 0x20 -> MemReq=0 immediately; after release 0x20 misses and refetches from 0x20.
- With INST_CACHE_STATS_EN: cold miss plus 3 hits -> MissCount=1, HitCount=4 (the post-DONE hit on 0x40 counts).
